// File: rtl/axil_pkg.sv
// Shared types for the P-bus to AXI4-Lite translator: response codes, FSM states,
// the CPU memory-access descriptor and a size decoding helper.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_RESP,
    ACK
  } state_e;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } mem_op_e;

  // Access size is carried as log2(bytes).
  typedef enum logic [1:0] {
    SZ_1 = 2'd0,
    SZ_2 = 2'd1,
    SZ_4 = 2'd2,
    SZ_8 = 2'd3
  } mem_size_e;

  typedef struct packed {
    mem_op_e   op;
    mem_size_e size;
  } memory_access_t;

  function automatic logic [3:0] size_to_bytes(input mem_size_e size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/axil_lane_align.sv
// Byte-lane steering between the right-justified CPU view and the AXI data bus:
// store shift and strobes, load shift with zero extension, misalignment detect.
module axil_lane_align
  import axil_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [OFFW-1:0]   i_req_offset,
  input  mem_size_e         i_req_size,
  input  logic [XLEN-1:0]   i_store_data,
  output logic [XLEN/8-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_wdata,
  output logic              o_misaligned,
  input  logic [OFFW-1:0]   i_rsp_offset,
  input  mem_size_e         i_rsp_size,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_load_data
);

  localparam int LANES = XLEN / 8;

  logic [3:0]      w_req_bytes;
  logic [3:0]      w_rsp_bytes;
  logic [XLEN-1:0] w_rd_shifted;

  assign w_req_bytes  = size_to_bytes(i_req_size);
  assign w_rsp_bytes  = size_to_bytes(i_rsp_size);
  assign o_wdata      = i_store_data << {i_req_offset, 3'b000};
  assign w_rd_shifted = i_rdata >> {i_rsp_offset, 3'b000};

  // An access wider than the bus can never be aligned, so it is flagged too.
  assign o_misaligned = (int'(w_req_bytes) > LANES) ||
                        ((i_req_offset & OFFW'(w_req_bytes - 4'd1)) != '0);

  always_comb begin
    o_wstrb = '0;
    for (int b = 0; b < LANES; b++) begin
      if ((b >= int'(i_req_offset)) && (b < int'(i_req_offset) + int'(w_req_bytes))) begin
        o_wstrb[b] = 1'b1;
      end
    end
  end

  always_comb begin
    o_load_data = '0;
    for (int b = 0; b < LANES; b++) begin
      if (b < int'(w_rsp_bytes)) begin
        o_load_data[8*b +: 8] = w_rd_shifted[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_translator.sv
// Turns one held P-bus request into a single-beat AXI4-Lite read or write and
// completes it with a one-cycle p_ack; errors and timeouts set a sticky flag.
module axil_translator
  import axil_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p_cycle,
  input  logic [31:0]           p_paddr,
  input  memory_access_t        p_access,
  input  logic [XLEN-1:0]       p_data_out,
  output logic [3:0][XLEN-1:0]  p_data_in,
  output logic                  p_ack,
  output logic [31:0]           m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [XLEN-1:0]       m_axi_wdata,
  output logic [XLEN/8-1:0]     m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [31:0]           m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [XLEN-1:0]       m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  bus_error,
  input  logic                  bus_error_clr
);

  localparam int          OFFW     = $clog2(XLEN / 8);
  localparam int          LANES    = XLEN / 8;
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic             w_awvalid_next, w_wvalid_next, w_bready_next, w_arvalid_next, w_rready_next;
  logic [31:0]      r_addr;
  logic [31:0]      r_tmo;
  logic [XLEN-1:0]  r_wdata;
  logic [XLEN-1:0]  r_rdata;
  logic [LANES-1:0] r_wstrb;
  logic [OFFW-1:0]  r_offset;
  mem_size_e        r_size;
  logic             r_is_load;
  logic             r_bus_error;

  logic             w_start, w_err_set, w_capture, w_load_ones;
  logic             w_busy, w_timeout, w_misaligned;
  logic [LANES-1:0] w_wstrb;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_load_data;

  axil_lane_align #(
    .XLEN (XLEN),
    .OFFW (OFFW)
  ) u_align (
    .i_req_offset (p_paddr[OFFW-1:0]),
    .i_req_size   (p_access.size),
    .i_store_data (p_data_out),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .i_rsp_offset (r_offset),
    .i_rsp_size   (r_size),
    .i_rdata      (m_axi_rdata),
    .o_load_data  (w_load_data)
  );

  assign w_busy    = (r_state != IDLE) && (r_state != ACK);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_busy && (r_tmo == TMO_LAST);

  always_comb begin
    w_state_next   = r_state;
    w_awvalid_next = r_awvalid;
    w_wvalid_next  = r_wvalid;
    w_bready_next  = r_bready;
    w_arvalid_next = r_arvalid;
    w_rready_next  = r_rready;
    w_start        = 1'b0;
    w_err_set      = 1'b0;
    w_capture      = 1'b0;
    w_load_ones    = 1'b0;

    case (r_state)
      IDLE: begin
        if (p_cycle) begin
          w_start = 1'b1;
          if (w_misaligned) begin
            w_state_next = ACK;
            w_err_set    = 1'b1;
            w_load_ones  = (p_access.op == LOAD);
          end else if (p_access.op == STORE) begin
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
            w_state_next   = WR_ADDR;
          end else begin
            w_arvalid_next = 1'b1;
            w_state_next   = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        w_awvalid_next = r_awvalid && !m_axi_awready;
        w_wvalid_next  = r_wvalid && !m_axi_wready;
        if (!w_awvalid_next && !w_wvalid_next) begin
          w_bready_next = 1'b1;
          w_state_next  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          w_bready_next = 1'b0;
          w_state_next  = ACK;
          w_err_set     = (m_axi_bresp != RESP_OKAY);
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_state_next   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid) begin
          w_rready_next = 1'b0;
          w_state_next  = ACK;
          if (m_axi_rresp != RESP_OKAY) begin
            w_err_set   = 1'b1;
            w_load_ones = 1'b1;
          end else begin
            w_capture = 1'b1;
          end
        end
      end
      ACK: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // A response landing in the final allowed cycle still completes normally.
    if (w_timeout && (w_state_next != ACK)) begin
      w_state_next   = ACK;
      w_awvalid_next = 1'b0;
      w_wvalid_next  = 1'b0;
      w_bready_next  = 1'b0;
      w_arvalid_next = 1'b0;
      w_rready_next  = 1'b0;
      w_err_set      = 1'b1;
      w_load_ones    = r_is_load;
      w_capture      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_awvalid <= w_awvalid_next;
      r_wvalid  <= w_wvalid_next;
      r_bready  <= w_bready_next;
      r_arvalid <= w_arvalid_next;
      r_rready  <= w_rready_next;
    end
  end

  // Request fields are frozen at start so AXI payloads hold steady under valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_offset    <= '0;
      r_size      <= SZ_1;
      r_is_load   <= 1'b0;
      r_tmo       <= '0;
      r_rdata     <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr    <= {p_paddr[31:OFFW], {OFFW{1'b0}}};
        r_wdata   <= w_wdata;
        r_wstrb   <= w_wstrb;
        r_offset  <= p_paddr[OFFW-1:0];
        r_size    <= p_access.size;
        r_is_load <= (p_access.op == LOAD);
        r_tmo     <= '0;
      end else if (w_busy) begin
        r_tmo <= r_tmo + 32'd1;
      end
      if (w_load_ones) begin
        r_rdata <= '1;
      end else if (w_capture) begin
        r_rdata <= w_load_data;
      end
      if (w_err_set) begin
        r_bus_error <= 1'b1;
      end else if (bus_error_clr) begin
        r_bus_error <= 1'b0;
      end
    end
  end

  assign m_axi_awaddr  = r_addr;
  assign m_axi_araddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign p_ack         = (r_state == ACK);
  assign bus_error     = r_bus_error;
  assign p_data_in[0]  = r_rdata;
  assign p_data_in[3:1] = '0;

endmodule

// File: tb/tb_axil_translator.sv
// Randomized and directed bench for axil_translator; expected values come from an
// arithmetic model of lane steering, alignment and error rules.
module tb_axil_translator;
  import axil_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 p_cycle;
  logic [31:0]          p_paddr;
  memory_access_t       p_access;
  logic [63:0]          p_data_out;
  logic [3:0][63:0]     p_data_in;
  logic                 p_ack;
  logic [31:0]          m_axi_awaddr;
  logic                 m_axi_awvalid, m_axi_awready;
  logic [63:0]          m_axi_wdata;
  logic [7:0]           m_axi_wstrb;
  logic                 m_axi_wvalid, m_axi_wready;
  logic [1:0]           m_axi_bresp;
  logic                 m_axi_bvalid, m_axi_bready;
  logic [31:0]          m_axi_araddr;
  logic                 m_axi_arvalid, m_axi_arready;
  logic [63:0]          m_axi_rdata;
  logic [1:0]           m_axi_rresp;
  logic                 m_axi_rvalid, m_axi_rready;
  logic                 bus_error, bus_error_clr;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic        issued;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          ackFirst;
    int          ackCount;
    int          rspCyc;
    int          arCycles;
    logic        breadyEarly;
    logic [63:0] rdata;
    logic [63:0] upperOr;
  } obs_t;

  always #5 clk = ~clk;

  axil_translator #(
    .XLEN           (64),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .p_cycle       (p_cycle),
    .p_paddr       (p_paddr),
    .p_access      (p_access),
    .p_data_out    (p_data_out),
    .p_data_in     (p_data_in),
    .p_ack         (p_ack),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .bus_error     (bus_error),
    .bus_error_clr (bus_error_clr)
  );

  function automatic int bytes_of(input mem_size_e s);
    return 1 << int'(s);
  endfunction

  function automatic logic [7:0] model_strb(input int nBytes, input int off);
    int strb;
    strb = ((1 << nBytes) - 1) << off;
    return strb[7:0];
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] d, input int off);
    return d << (8 * off);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input int nBytes, input int off);
    logic [63:0] v;
    v = rd >> (8 * off);
    if (nBytes < 8) v = v & ((64'd1 << (8 * nBytes)) - 64'd1);
    return v;
  endfunction

  // Acts as requester and slave for one transaction; starts and ends just after a posedge.
  task automatic run_txn(input logic isStore, input mem_size_e sz, input logic [31:0] addr,
                         input logic [63:0] data, input int awDly, input int wDly, input int arDly,
                         input int rspDly, input logic [1:0] resp, input logic [63:0] rdata,
                         output obs_t o);
    int awCnt = 0, wCnt = 0, arCnt = 0, rspCnt = 0;
    logic awDone = 1'b0, wDone = 1'b0;
    o.issued = 1'b0; o.addr = '0; o.wdata = '0; o.wstrb = '0;
    o.ackFirst = -1; o.ackCount = 0; o.rspCyc = -1; o.arCycles = 0;
    o.breadyEarly = 1'b0; o.rdata = '0; o.upperOr = '0;
    p_cycle    = 1'b1;
    p_paddr    = addr;
    p_access   = '{op: (isStore ? STORE : LOAD), size: sz};
    p_data_out = data;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (m_axi_bready && !(awDone && wDone)) o.breadyEarly = 1'b1;
      if (m_axi_awvalid) begin
        o.issued = 1'b1; o.addr = m_axi_awaddr;
        if (awCnt >= awDly) begin m_axi_awready = 1'b1; awDone = 1'b1; end
        awCnt++;
      end
      if (m_axi_wvalid) begin
        o.issued = 1'b1; o.wdata = m_axi_wdata; o.wstrb = m_axi_wstrb;
        if (wCnt >= wDly) begin m_axi_wready = 1'b1; wDone = 1'b1; end
        wCnt++;
      end
      if (m_axi_arvalid) begin
        o.issued = 1'b1; o.addr = m_axi_araddr; o.arCycles++;
        if (arCnt >= arDly) m_axi_arready = 1'b1;
        arCnt++;
      end
      if (m_axi_bready) begin
        if (rspCnt >= rspDly) begin m_axi_bvalid = 1'b1; m_axi_bresp = resp; o.rspCyc = cyc; end
        rspCnt++;
      end
      if (m_axi_rready) begin
        if (rspCnt >= rspDly) begin
          m_axi_rvalid = 1'b1; m_axi_rresp = resp; m_axi_rdata = rdata; o.rspCyc = cyc;
        end
        rspCnt++;
      end
      if (p_ack) begin
        o.ackCount++;
        if (o.ackFirst < 0) begin
          o.ackFirst = cyc;
          o.rdata    = p_data_in[0];
          o.upperOr  = p_data_in[1] | p_data_in[2] | p_data_in[3];
        end
      end
      @(posedge clk);
      #1;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid  = 1'b0; m_axi_rvalid = 1'b0;
      if (o.ackFirst >= 0) p_cycle = 1'b0;
      if (o.ackFirst >= 0 && cyc >= o.ackFirst + 2) break;
    end
    p_cycle = 1'b0;
  endtask

  task automatic clear_error();
    bus_error_clr = 1'b1;
    @(posedge clk);
    #1;
    bus_error_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checkCount++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL reset_handshake got=%b want=00000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
    end
    checkCount++;
    if ({p_ack, bus_error} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL reset_ack_err got=%b want=00", {p_ack, bus_error});
    end
    checkCount++;
    if (p_data_in !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_data got=%h want=0", p_data_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store8();
    obs_t o;
    run_txn(1'b1, SZ_8, 32'h0000_1000, 64'h1122334455667788, 0, 0, 0, 0, 2'd0, '0, o);
    checkCount++;
    if (o.wstrb !== 8'hFF || o.wdata !== 64'h1122334455667788 || o.addr !== 32'h1000) begin
      failCount++;
      $display("[TB] FAIL store8_payload got addr=%h strb=%h data=%h want 1000/ff/1122334455667788",
               o.addr, o.wstrb, o.wdata);
    end
    checkCount++;
    if (o.rspCyc < 0 || o.ackFirst !== o.rspCyc + 1 || o.ackCount !== 1) begin
      failCount++;
      $display("[TB] FAIL store8_ack got ack@%0d x%0d want ack@%0d x1", o.ackFirst, o.ackCount, o.rspCyc + 1);
    end
    checkCount++;
    if (bus_error !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL store8_err got=%b want=0", bus_error);
    end
  endtask

  task automatic test_store1_late_wready();
    obs_t o;
    run_txn(1'b1, SZ_1, 32'h0000_1003, 64'h0000_0000_0000_00AB, 0, 3, 0, 1, 2'd0, '0, o);
    checkCount++;
    if (o.wstrb !== model_strb(1, 3) || o.wdata !== model_wdata(64'hAB, 3)) begin
      failCount++;
      $display("[TB] FAIL store1_lane got strb=%h data=%h want strb=%h data=%h",
               o.wstrb, o.wdata, model_strb(1, 3), model_wdata(64'hAB, 3));
    end
    checkCount++;
    if (o.breadyEarly !== 1'b0 || o.ackCount !== 1) begin
      failCount++;
      $display("[TB] FAIL store1_bready early=%b acks=%0d want early=0 acks=1", o.breadyEarly, o.ackCount);
    end
  endtask

  task automatic test_load4();
    obs_t o;
    run_txn(1'b0, SZ_4, 32'h0000_2004, '0, 0, 0, 1, 0, 2'd0, 64'hDEADBEEF_01234567, o);
    checkCount++;
    if (o.rdata !== 64'h0000_0000_DEAD_BEEF || o.upperOr !== '0) begin
      failCount++;
      $display("[TB] FAIL load4_data got=%h upper=%h want=00000000deadbeef upper=0", o.rdata, o.upperOr);
    end
    checkCount++;
    if (o.addr !== 32'h0000_2000 || o.ackCount !== 1) begin
      failCount++;
      $display("[TB] FAIL load4_addr got addr=%h acks=%0d want 2000 acks=1", o.addr, o.ackCount);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_txn(1'b0, SZ_2, 32'h0000_3001, '0, 0, 0, 0, 0, 2'd0, '0, o);
    checkCount++;
    if (o.issued !== 1'b0 || o.ackFirst !== 1 || o.rdata !== '1) begin
      failCount++;
      $display("[TB] FAIL misaligned_load issued=%b ack@%0d data=%h want issued=0 ack@1 data=all-ones",
               o.issued, o.ackFirst, o.rdata);
    end
    checkCount++;
    if (bus_error !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL misaligned_err got=%b want=1", bus_error);
    end
    clear_error();
    checkCount++;
    if (bus_error !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL misaligned_clr got=%b want=0", bus_error);
    end
    // Clear requested in the very cycle a misaligned store raises the error.
    p_cycle = 1'b1; p_paddr = 32'h0000_3005; p_access = '{op: STORE, size: SZ_4};
    bus_error_clr = 1'b1;
    @(posedge clk);
    #1;
    bus_error_clr = 1'b0;
    checkCount++;
    if (bus_error !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL set_beats_clr got=%b want=1", bus_error);
    end
    @(negedge clk);
    checkCount++;
    if (p_ack !== 1'b1 || m_axi_awvalid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL misaligned_store ack=%b awvalid=%b want ack=1 awvalid=0", p_ack, m_axi_awvalid);
    end
    @(posedge clk);
    #1;
    p_cycle = 1'b0;
    clear_error();
  endtask

  task automatic test_decerr_read();
    obs_t o;
    run_txn(1'b0, SZ_8, 32'h0000_4000, '0, 0, 0, 0, 2, 2'd3, 64'h0123_4567_89AB_CDEF, o);
    checkCount++;
    if (o.rdata !== '1 || bus_error !== 1'b1 || o.ackCount !== 1) begin
      failCount++;
      $display("[TB] FAIL decerr_read data=%h err=%b acks=%0d want all-ones/1/1", o.rdata, bus_error, o.ackCount);
    end
    clear_error();
  endtask

  task automatic test_random();
    obs_t        o;
    logic        isStore, mis, expErr;
    mem_size_e   sz;
    int          nb, off;
    logic [31:0] addr;
    logic [63:0] data, rd, expRd;
    logic [1:0]  resp;
    for (int n = 0; n < 30; n++) begin
      isStore = 1'($urandom_range(0, 1));
      sz      = mem_size_e'($urandom_range(0, 3));
      nb      = bytes_of(sz);
      addr    = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(nb) - 32'd1);
      off     = int'(addr[2:0]);
      mis     = (off % nb) != 0;
      resp    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      data    = {$urandom, $urandom};
      rd      = {$urandom, $urandom};
      run_txn(isStore, sz, addr, data, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), resp, rd, o);
      expErr = mis || (resp != 2'd0);
      checkCount++;
      if (o.ackCount !== 1 || o.issued !== !mis) begin
        failCount++;
        $display("[TB] FAIL rand%0d_flow acks=%0d issued=%b want acks=1 issued=%b", n, o.ackCount, o.issued, !mis);
      end
      if (!mis) begin
        checkCount++;
        if (o.addr !== {addr[31:3], 3'b000}) begin
          failCount++;
          $display("[TB] FAIL rand%0d_addr got=%h want=%h", n, o.addr, {addr[31:3], 3'b000});
        end
      end
      if (isStore && !mis) begin
        checkCount++;
        if (o.wstrb !== model_strb(nb, off) || o.wdata !== model_wdata(data, off)) begin
          failCount++;
          $display("[TB] FAIL rand%0d_store strb=%h data=%h want strb=%h data=%h", n, o.wstrb, o.wdata,
                   model_strb(nb, off), model_wdata(data, off));
        end
      end
      if (!isStore) begin
        expRd = expErr ? '1 : model_load(rd, nb, off);
        checkCount++;
        if (o.rdata !== expRd) begin
          failCount++;
          $display("[TB] FAIL rand%0d_load got=%h want=%h", n, o.rdata, expRd);
        end
      end
      checkCount++;
      if (bus_error !== expErr) begin
        failCount++;
        $display("[TB] FAIL rand%0d_err got=%b want=%b", n, bus_error, expErr);
      end
      clear_error();
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    int   lateBad = 0;
    run_txn(1'b0, SZ_8, 32'h0000_5000, '0, 0, 0, 1000, 0, 2'd0, '0, o);
    checkCount++;
    if (o.arCycles !== 16 || o.ackFirst !== 17 || o.ackCount !== 1) begin
      failCount++;
      $display("[TB] FAIL timeout_timing arvalid_cycles=%0d ack@%0d acks=%0d want 16/17/1",
               o.arCycles, o.ackFirst, o.ackCount);
    end
    checkCount++;
    if (o.rdata !== '1 || bus_error !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL timeout_result data=%h err=%b want all-ones/1", o.rdata, bus_error);
    end
    m_axi_rvalid = 1'b1; m_axi_rresp = 2'd0; m_axi_rdata = 64'h5555_5555_5555_5555;
    repeat (3) begin
      @(negedge clk);
      if (m_axi_rready || m_axi_arvalid || p_ack) lateBad++;
    end
    m_axi_rvalid = 1'b0;
    checkCount++;
    if (lateBad !== 0) begin
      failCount++;
      $display("[TB] FAIL late_response got=%0d consuming cycles want=0", lateBad);
    end
    @(posedge clk);
    #1;
    clear_error();
  endtask

  task automatic test_reset_midwrite();
    int acks = 0;
    p_cycle = 1'b1; p_paddr = 32'h0000_6000; p_access = '{op: STORE, size: SZ_8};
    p_data_out = 64'hCAFE_F00D_0000_0001;
    repeat (3) @(negedge clk);
    checkCount++;
    if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL pending_write got=%b want=11", {m_axi_awvalid, m_axi_wvalid});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if ({m_axi_awvalid, m_axi_wvalid} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL async_abort got=%b want=00", {m_axi_awvalid, m_axi_wvalid});
    end
    p_cycle = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (p_ack) acks++;
    end
    checkCount++;
    if (acks !== 0) begin
      failCount++;
      $display("[TB] FAIL abort_no_ack got=%0d acks want=0", acks);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    p_cycle = 1'b0; p_paddr = '0; p_access = '{op: LOAD, size: SZ_1}; p_data_out = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = '0; m_axi_rvalid = 1'b0; m_axi_rresp = '0; m_axi_rdata = '0;
    bus_error_clr = 1'b0;
    test_reset();
    test_store8();
    test_store1_late_wready();
    test_load4();
    test_misaligned();
    test_decerr_read();
    test_random();
    test_timeout();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
